// File: rtl/cmat_row_buffer.sv
// ---------------------------------------------------------------------------
// cmat_row_buffer
//
// Upstream feeder for the complex triangular-matrix inverter. It captures one
// SIZE x SIZE matrix of complex FP64 elements from a row-major element stream.
// It then serves whole rows by index until the consumer releases the buffer.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   elem_i           complex element {imag[127:64], real[63:0]}
//   elem_valid_i     element beat valid
//   elem_last_i      marks the final element of the matrix
//   elem_ready_o     element accepted when valid && ready (high while loading)
//   row_addr_i       requested row index
//   row_addr_valid_i row request strobe (served only while full)
//   row_o            row data, column j at bits [128*j +: 128]
//   row_addr_o       index of the row currently on row_o
//   row_valid_o      row_o / row_addr_o valid (one cycle after the request)
//   start_o          one-cycle pulse: matrix completely loaded
//   release_i        consumer finished, buffer may be reloaded
//   flush_i          synchronous abort back to an empty load
//   full_o           high while the buffer holds a complete matrix
//   err_o            sticky framing error (cleared by flush or reset)
// ---------------------------------------------------------------------------
module cmat_row_buffer #(
    parameter  int SIZE = 16,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [127:0]          elem_i,
    input  logic                  elem_valid_i,
    input  logic                  elem_last_i,
    output logic                  elem_ready_o,
    input  logic [AW-1:0]         row_addr_i,
    input  logic                  row_addr_valid_i,
    output logic [SIZE*128-1:0]   row_o,
    output logic [AW-1:0]         row_addr_o,
    output logic                  row_valid_o,
    output logic                  start_o,
    input  logic                  release_i,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  err_o
);

    localparam int KW = 2 * AW;
    localparam int RW = SIZE * 128;
    // SIZE is a power of two, so the last element index is all ones.
    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic              elem_ready_q, elem_ready_d;
    logic              full_q, full_d;
    logic              start_q, start_d;
    logic              err_q, err_d;
    logic              row_valid_q, row_valid_d;
    logic [RW-1:0]     row_q, row_d;
    logic [AW-1:0]     row_addr_q, row_addr_d;

    // Storage is held row-wise so that a whole row is read with one index.
    logic [RW-1:0]     mem_q [SIZE];
    logic              wr_en_s;
    logic [AW-1:0]     wr_row_s;
    logic [AW-1:0]     wr_col_s;
    logic [RW-1:0]     rd_row_s;

    assign wr_row_s = k_q[KW-1:AW];
    assign wr_col_s = k_q[AW-1:0];
    assign rd_row_s = mem_q[row_addr_i];

    // Next-state, counter, write-enable and output computation.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        elem_ready_d = elem_ready_q;
        full_d       = full_q;
        start_d      = 1'b0;
        err_d        = err_q;
        row_valid_d  = 1'b0;
        row_d        = row_q;
        row_addr_d   = row_addr_q;
        wr_en_s      = 1'b0;

        if (flush_i) begin
            // Abort: any beat in this cycle is dropped and no row is served.
            state_d      = ST_LOAD;
            k_d          = {KW{1'b0}};
            elem_ready_d = 1'b1;
            full_d       = 1'b0;
            err_d        = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (elem_valid_i) begin
                        wr_en_s = 1'b1;
                        if ((k_q == K_LAST) && elem_last_i) begin
                            k_d          = {KW{1'b0}};
                            state_d      = ST_FULL;
                            start_d      = 1'b1;
                            elem_ready_d = 1'b0;
                            full_d       = 1'b1;
                        end else if ((k_q != K_LAST) && !elem_last_i) begin
                            k_d = k_q + {{(KW-1){1'b0}}, 1'b1};
                        end else begin
                            // Framing error: last flag disagrees with the count.
                            // Restarting at 0 discards the partial matrix.
                            err_d = 1'b1;
                            k_d   = {KW{1'b0}};
                        end
                    end else begin
                        k_d = k_q;
                    end
                end
                ST_FULL: begin
                    // A request is served from the old contents even when
                    // release arrives in the same cycle.
                    if (row_addr_valid_i) begin
                        row_valid_d = 1'b1;
                        row_addr_d  = row_addr_i;
                        row_d       = rd_row_s;
                    end else begin
                        row_valid_d = 1'b0;
                    end
                    if (release_i) begin
                        state_d      = ST_LOAD;
                        elem_ready_d = 1'b1;
                        full_d       = 1'b0;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d      = ST_LOAD;
                    k_d          = {KW{1'b0}};
                    elem_ready_d = 1'b1;
                    full_d       = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_LOAD;
            k_q          <= {KW{1'b0}};
            elem_ready_q <= 1'b1;
            full_q       <= 1'b0;
            start_q      <= 1'b0;
            err_q        <= 1'b0;
            row_valid_q  <= 1'b0;
            row_q        <= {RW{1'b0}};
            row_addr_q   <= {AW{1'b0}};
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            elem_ready_q <= elem_ready_d;
            full_q       <= full_d;
            start_q      <= start_d;
            err_q        <= err_d;
            row_valid_q  <= row_valid_d;
            row_q        <= row_d;
            row_addr_q   <= row_addr_d;
        end
    end

    // Element storage; deliberately not reset, its contents are only
    // meaningful after a complete load.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_row_s][{wr_col_s, 7'd0} +: 128] <= elem_i;
        end
    end

    assign elem_ready_o = elem_ready_q;
    assign full_o       = full_q;
    assign start_o      = start_q;
    assign err_o        = err_q;
    assign row_valid_o  = row_valid_q;
    assign row_o        = row_q;
    assign row_addr_o   = row_addr_q;

endmodule

// File: tb/tb_cmat_row_buffer.sv
module tb_cmat_row_buffer;

    localparam int SIZE = 16;
    localparam int AW   = 4;
    localparam int N    = SIZE * SIZE;
    localparam int RW   = SIZE * 128;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [127:0]      elem_i;
    logic              elem_valid_i;
    logic              elem_last_i;
    logic              elem_ready_o;
    logic [AW-1:0]     row_addr_i;
    logic              row_addr_valid_i;
    logic [RW-1:0]     row_o;
    logic [AW-1:0]     row_addr_o;
    logic              row_valid_o;
    logic              start_o;
    logic              release_i;
    logic              flush_i;
    logic              full_o;
    logic              err_o;

    cmat_row_buffer #(.SIZE(SIZE)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .elem_i           (elem_i),
        .elem_valid_i     (elem_valid_i),
        .elem_last_i      (elem_last_i),
        .elem_ready_o     (elem_ready_o),
        .row_addr_i       (row_addr_i),
        .row_addr_valid_i (row_addr_valid_i),
        .row_o            (row_o),
        .row_addr_o       (row_addr_o),
        .row_valid_o      (row_valid_o),
        .start_o          (start_o),
        .release_i        (release_i),
        .flush_i          (flush_i),
        .full_o           (full_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } rowexp_t;

    rowexp_t        exp_q[$];
    rowexp_t        mon_x;
    logic [127:0]   m_mem [N];
    bit             m_load, m_start, m_err, m_rv;
    int             m_k;
    bit             mon_en;
    logic [AW-1:0]  last_addr;
    logic [RW-1:0]  last_row;
    int             n_checks = 0;
    int             n_errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_row(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            for (int j = 0; j < SIZE; j++) begin
                if (act[128*j +: 128] !== exp[128*j +: 128]) begin
                    $display("FAIL %s col %0d: got %h expected %h at %0t", nm, j,
                             act[128*j +: 128], exp[128*j +: 128], $time);
                    break;
                end
            end
        end
    endtask

    function automatic logic [RW-1:0] model_row(input int r);
        logic [RW-1:0] v;
        for (int j = 0; j < SIZE; j++) v[128*j +: 128] = m_mem[r*SIZE + j];
        return v;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] pat(input int k);
        logic [63:0] kk;
        kk = 64'(k);
        return {kk, kk + 64'h3ff0000000000000};
    endfunction

    // Drive one cycle of inputs, then advance the reference model.
    task automatic step(input logic v, input logic [127:0] e, input logic last,
                        input logic rq, input logic [AW-1:0] ra,
                        input logic rel, input logic fl);
        elem_valid_i     = v;
        elem_i           = e;
        elem_last_i      = last;
        row_addr_valid_i = rq;
        row_addr_i       = ra;
        release_i        = rel;
        flush_i          = fl;
        @(posedge clk_i);
        m_start = 1'b0;
        m_rv    = 1'b0;
        if (fl) begin
            m_load = 1'b1;
            m_k    = 0;
            m_err  = 1'b0;
        end else if (m_load) begin
            if (v) begin
                m_mem[m_k] = e;
                if (last && m_k == N-1) begin
                    m_load  = 1'b0;
                    m_k     = 0;
                    m_start = 1'b1;
                end else if (!last && m_k != N-1) begin
                    m_k++;
                end else begin
                    m_err = 1'b1;
                    m_k   = 0;
                end
            end
        end else begin
            if (rq) begin
                exp_q.push_back('{ra, model_row(int'(ra))});
                m_rv = 1'b1;
            end
            if (rel) m_load = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 128'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // Beats with random gaps and random (ignored) row requests while loading.
    task automatic load(input int nbeats, input int last_at, input bit use_pat, input int flush_at);
        for (int i = 0; i < nbeats; i++) begin
            while ($urandom_range(0, 3) == 0)
                step(1'b0, rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, SIZE-1)), 1'b0, 1'b0);
            step(1'b1, use_pat ? pat(i) : rnd128(), 1'(i == last_at),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, SIZE-1)), 1'b0, 1'(i == flush_at));
        end
    endtask

    task automatic rand_reads(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 128'd0, 1'b0, 1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, SIZE-1)), 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_load = 1'b1; m_k = 0; m_err = 1'b0; m_start = 1'b0; m_rv = 1'b0;
        exp_q.delete();
        last_addr = '0;
        last_row  = '0;
    endtask

    // Monitor: compares control outputs every cycle and pops the scoreboard
    // whenever the DUT presents a row.
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("start_o", start_o, m_start);
            chk("full_o", full_o, !m_load);
            chk("elem_ready_o", elem_ready_o, m_load);
            chk("err_o", err_o, m_err);
            chk("row_valid_o", row_valid_o, m_rv);
            if (row_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL row_unexpected: got row %0d expected none at %0t", row_addr_o, $time);
                end else begin
                    mon_x = exp_q.pop_front();
                    chk("row_addr_o", row_addr_o, mon_x.addr);
                    chk_row("row_o", row_o, mon_x.data);
                    last_addr = mon_x.addr;
                    last_row  = mon_x.data;
                end
            end else begin
                chk("row_addr_hold", row_addr_o, last_addr);
                chk_row("row_o_hold", row_o, last_row);
            end
        end
    end

    initial begin
        mon_en = 1'b0;
        rst_ni = 1'b0;
        elem_i = '0; elem_valid_i = 1'b0; elem_last_i = 1'b0;
        row_addr_i = '0; row_addr_valid_i = 1'b0; release_i = 1'b0; flush_i = 1'b0;
        model_reset();
        #12;
        chk("rst_elem_ready", elem_ready_o, 1'b1);
        chk("rst_row_valid", row_valid_o, 1'b0);
        chk("rst_start", start_o, 1'b0);
        chk("rst_full", full_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_row_addr", row_addr_o, 4'd0);
        chk_row("rst_row", row_o, '0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;

        // Patterned full load, then rows 0, 5, 15 back to back.
        load(N, N-1, 1'b1, -1);
        step(1'b0, 128'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b0, 128'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b0, 128'd0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
        idle();
        rand_reads(30);

        // Release together with a request for row 3.
        step(1'b0, 128'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);

        // Early last flag, then missing last flag, then a clean load.
        load(101, 100, 1'b1, -1);
        load(N, -1, 1'b0, -1);
        load(N, N-1, 1'b0, -1);
        rand_reads(20);

        // Flush mid-load on a valid beat at k=40, then a clean reload.
        step(1'b0, 128'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        load(41, -1, 1'b1, 40);
        load(N, N-1, 1'b0, -1);
        rand_reads(20);

        // Flush while full with a request in the same cycle.
        step(1'b0, 128'd0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
        idle();
        load(N, N-1, 1'b0, -1);
        rand_reads(10);

        // Asynchronous reset while a row is being presented.
        step(1'b0, 128'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        @(negedge clk_i);
        #1;
        chk("pre_async_row_valid", row_valid_o, 1'b1);
        mon_en = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("async_row_valid", row_valid_o, 1'b0);
        chk("async_elem_ready", elem_ready_o, 1'b1);
        chk("async_full", full_o, 1'b0);
        chk("async_start", start_o, 1'b0);
        chk("async_err", err_o, 1'b0);
        chk("async_row_addr", row_addr_o, 4'd0);
        chk_row("async_row", row_o, '0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
        mon_en = 1'b1;
        load(N, N-1, 1'b1, -1);
        rand_reads(10);
        idle();
        idle();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d rows outstanding expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cmat_row_buffer.md
Name: cmat_row_buffer

Overview:
- Upstream feeder for the complex triangular-matrix inverter: captures one SIZE x SIZE complex double matrix from a per-element stream and serves whole rows on request.
- Row-major load, one element per accepted beat; start_o pulses once when the matrix is complete. Rows are then read by address with one-cycle latency until the consumer issues release_i.

Parameters:
- SIZE, 16, matrix dimension (rows = columns); power of two, minimum 2
- AW, $clog2(SIZE), row/column index width (derived, not overridable)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- elem_i  in  128  complex element {imag[127:64], real[63:0]}, FP64 each
- elem_valid_i  in  1  element beat valid
- elem_last_i  in  1  marks final element of the matrix
- elem_ready_o  out  1  element accepted when valid && ready
- row_addr_i  in  AW  requested row index
- row_addr_valid_i  in  1  row request strobe
- row_o  out  SIZE*128  row data, column j at bits [128*j +: 128]
- row_addr_o  out  AW  index of the row currently on row_o
- row_valid_o  out  1  row_o/row_addr_o valid
- start_o  out  1  one-cycle pulse: matrix loaded
- release_i  in  1  consumer finished, buffer may be reloaded
- flush_i  in  1  synchronous abort
- full_o  out  1  high while in FULL
- err_o  out  1  sticky framing error

Behaviour:
- Reset (async, rst_ni=0): state LOAD, elem counter 0, elem_ready_o=1, row_valid_o=0, row_addr_o=0, row_o=0, start_o=0, full_o=0, err_o=0. Storage array is not reset.
- Storage: SIZE*SIZE x 128 flops. The counter k (width 2*AW) maps to row = k[2*AW-1:AW] and column = k[AW-1:0].
- LOAD state:
  - elem_ready_o=1.
  - On an accepted beat, store elem_i at (row, col).
  - If k == SIZE*SIZE-1 and elem_last_i=1: k <= 0, go to FULL, assert start_o in the next cycle (a single cycle).
  - Otherwise k <= k+1.
- Framing error in LOAD:
  - Condition: elem_last_i=1 on an accepted beat with k != SIZE*SIZE-1, or elem_last_i=0 on the beat with k == SIZE*SIZE-1.
  - Response: err_o <= 1 (sticky), k <= 0, stay in LOAD, no start_o. Already-written data is discarded logically.
- FULL state:
  - elem_ready_o=0, full_o=1.
  - A request with row_addr_valid_i=1 in cycle N gives row_o = stored row row_addr_i, row_addr_o = row_addr_i and row_valid_o=1 in cycle N+1.
  - With no request, row_valid_o=0 and row_o/row_addr_o hold their last values.
  - Back-to-back requests are accepted every cycle; throughput is 1 row/cycle.
- Requests while in LOAD are ignored (row_valid_o stays 0).
- release_i in FULL: go to LOAD next cycle. A request in the same cycle as release_i is still honoured from the old contents. release_i in LOAD is ignored.
- flush_i (any state, highest priority after reset):
  - Next cycle: state LOAD, k=0, row_valid_o=0, start_o=0, err_o=0.
  - An element beat in the flush cycle is not stored (elem_ready_o still 1 in LOAD; the beat is dropped).
- start_o and request handling: a request in the same cycle start_o is high is legal and is served.
- No arithmetic on data; elements pass bit-exact.

Test Plan:
- Load 256 beats with elem_i = {64'(k), 64'(k)+64'h3ff0000000000000}, elem_last_i on k=255 -> start_o high exactly one cycle after beat 255, full_o=1, elem_ready_o=0.
- After the full load, request rows 0, 5, 15 on consecutive cycles -> row_valid_o high on the next three cycles, row_addr_o=0/5/15, row_o column j of row r = element k=16r+j.
- elem_last_i on k=100 -> err_o=1, no start_o, still LOAD. A following clean 256-beat load completes, start_o pulses, err_o stays 1.
- In FULL, assert release_i together with a request for row 3 -> row 3 is returned next cycle and elem_ready_o=1 the same cycle. A new load then overwrites, and reads return the new data.
- Mid-load (k=40) assert flush_i with elem_valid_i=1 -> that beat is dropped, k=0, err_o cleared. The next 256 beats alone produce start_o.
- Deassert rst_ni asynchronously during FULL with row_valid_o=1 -> all outputs reach reset values immediately, without a clock edge, and the block returns to LOAD.
